// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
//   Serial debug bridge: a host sends 8N1 command frames over i_pinRX and the
//   bridge turns them into single-cycle memory-map read/write strobes. Each
//   command is answered over o_pinTX (0x06 for a write, two data bytes for a
//   read).
//
//   Command frames (low byte first):
//     write : 'W'(0x57) addr_lo addr_hi data_lo data_hi  -> reply 0x06
//     read  : 'R'(0x52) addr_lo addr_hi                  -> reply data_lo data_hi
//
//   Ports
//     i_clk         system clock, rising edge
//     i_rst         asynchronous active-high reset
//     i_pinRX       serial input, idle high, asynchronous
//     o_pinTX       serial output, idle high
//     o_memAddr     memory-map address (holds between commands)
//     o_memDataOut  write data (holds between commands)
//     o_memWrEn     one-cycle write strobe
//     o_memRdEn     one-cycle read strobe
//     i_memDataIn   read data, valid combinationally while o_memRdEn is high
//     o_busy        parser not idle or transmitter active
module uart_mem_bridge #(
   parameter int BAUD_DIV     = 434,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pinRX,
   output logic        o_pinTX,
   output logic [15:0] o_memAddr,
   output logic [15:0] o_memDataOut,
   output logic        o_memWrEn,
   output logic        o_memRdEn,
   input  logic [15:0] i_memDataIn,
   output logic        o_busy
);

   localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
   localparam int          TO_TICKS  = TIMEOUT_BITS * BAUD_DIV;
   localparam int          TO_W      = $clog2(TO_TICKS + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

   localparam logic [7:0] OP_WR = 8'h57;
   localparam logic [7:0] OP_RD = 8'h52;
   localparam logic [7:0] ACK   = 8'h06;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {
      P_IDLE, P_ADDR_LO, P_ADDR_HI, P_DATA_LO, P_DATA_HI, P_MEM, P_RESP
   } p_state_t;

   // ---------------------------------------------------------------------
   // RX synchronizer; rx_prev is one more stage for falling-edge detection
   // ---------------------------------------------------------------------
   logic rx_s1, rx_s2, rx_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= i_pinRX;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // ---------------------------------------------------------------------
   // RX framer
   // ---------------------------------------------------------------------
   rx_state_t   rx_state, rx_next;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        byte_done, frame_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   always_comb begin
      rx_next   = rx_state;
      byte_done = 1'b0;
      frame_err = 1'b0;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
         // half-bit re-check rejects short low glitches
         RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_next   = RX_IDLE;
               byte_done = rx_s2;
               frame_err = !rx_s2;
            end
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
            end
            RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? 16'd0 : rx_cnt + 16'd1;
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_STOP:  rx_cnt <= (rx_cnt == BIT_LAST) ? 16'd0 : rx_cnt + 16'd1;
            default:  rx_cnt <= '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Command parser
   // ---------------------------------------------------------------------
   p_state_t        p_state, p_next;
   logic            is_wr;
   logic [7:0]      addr_lo, addr_hi, data_lo;
   logic [TO_W-1:0] to_cnt;
   logic            collecting, timeout;
   logic            tx_last_done;

   assign collecting = (p_state == P_ADDR_LO) || (p_state == P_ADDR_HI) ||
                       (p_state == P_DATA_LO) || (p_state == P_DATA_HI);
   assign timeout    = collecting && (to_cnt == TO_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) p_state <= P_IDLE;
      else       p_state <= p_next;
   end

   // byte_done is tested before timeout/frame_err so an arriving byte wins
   always_comb begin
      p_next    = p_state;
      o_memWrEn = 1'b0;
      o_memRdEn = 1'b0;
      case (p_state)
         P_IDLE: begin
            if (byte_done && (rx_shift == OP_WR || rx_shift == OP_RD))
               p_next = P_ADDR_LO;
         end
         P_ADDR_LO: begin
            if (byte_done)                 p_next = P_ADDR_HI;
            else if (frame_err || timeout) p_next = P_IDLE;
         end
         P_ADDR_HI: begin
            if (byte_done)                 p_next = is_wr ? P_DATA_LO : P_MEM;
            else if (frame_err || timeout) p_next = P_IDLE;
         end
         P_DATA_LO: begin
            if (byte_done)                 p_next = P_DATA_HI;
            else if (frame_err || timeout) p_next = P_IDLE;
         end
         P_DATA_HI: begin
            if (byte_done)                 p_next = P_MEM;
            else if (frame_err || timeout) p_next = P_IDLE;
         end
         P_MEM: begin
            o_memWrEn = is_wr;
            o_memRdEn = !is_wr;
            p_next    = P_RESP;
         end
         P_RESP:  if (tx_last_done) p_next = P_IDLE;
         default: p_next = P_IDLE;
      endcase
   end

   // Address/data bytes go to shadow registers so an aborted command leaves
   // the bus outputs untouched; the outputs update on the final byte only.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         is_wr        <= 1'b0;
         addr_lo      <= '0;
         addr_hi      <= '0;
         data_lo      <= '0;
         o_memAddr    <= '0;
         o_memDataOut <= '0;
         to_cnt       <= '0;
      end else begin
         if (!collecting || byte_done) to_cnt <= '0;
         else                          to_cnt <= to_cnt + 1'b1;

         if (p_state == P_IDLE && p_next == P_ADDR_LO)
            is_wr <= (rx_shift == OP_WR);

         if (byte_done) begin
            case (p_state)
               P_ADDR_LO: addr_lo <= rx_shift;
               P_ADDR_HI: begin
                  addr_hi <= rx_shift;
                  if (!is_wr) o_memAddr <= {rx_shift, addr_lo};
               end
               P_DATA_LO: data_lo <= rx_shift;
               P_DATA_HI: begin
                  o_memAddr    <= {addr_hi, addr_lo};
                  o_memDataOut <= {rx_shift, data_lo};
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // TX serializer; loaded during the MEM cycle so the start bit begins on
   // the following cycle. A pending high byte chains straight from stop.
   // ---------------------------------------------------------------------
   tx_state_t   tx_state, tx_next;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift, tx_hi;
   logic        tx_pend;
   logic        tx_bit_end;

   assign tx_bit_end   = (tx_cnt == BIT_LAST);
   assign tx_last_done = (tx_state == TX_STOP) && tx_bit_end && !tx_pend;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (p_state == P_MEM) tx_next = TX_START;
         TX_START: if (tx_bit_end) tx_next = TX_DATA;
         TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_bit_end) tx_next = tx_pend ? TX_START : TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_hi    <= '0;
         tx_pend  <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_cnt <= '0;
               tx_bit <= '0;
               if (p_state == P_MEM) begin
                  tx_shift <= is_wr ? ACK : i_memDataIn[7:0];
                  tx_hi    <= i_memDataIn[15:8];
                  tx_pend  <= !is_wr;
               end
            end
            TX_START: tx_cnt <= tx_bit_end ? 16'd0 : tx_cnt + 16'd1;
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt   <= '0;
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= tx_bit + 3'd1;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_pend) begin
                     tx_shift <= tx_hi;
                     tx_pend  <= 1'b0;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            default: tx_cnt <= '0;
         endcase
      end
   end

   // Line level is decoded from state so reset forces it high at once.
   always_comb begin
      case (tx_state)
         TX_START: o_pinTX = 1'b0;
         TX_DATA:  o_pinTX = tx_shift[0];
         default:  o_pinTX = 1'b1;
      endcase
   end

   assign o_busy = (p_state != P_IDLE) || (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge at BAUD_DIV=8, TIMEOUT_BITS=32.
module tb_uart_mem_bridge;
   localparam int BD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        tx;
   logic [15:0] addr, dout, din;
   logic        wr_en, rd_en, busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int          wr_cnt = 0, rd_cnt = 0, rd_cyc = 0;
   logic [15:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
   logic [7:0]  tx_q[$];
   int          tx_starts[$];
   int          tx_bad = 0;

   uart_mem_bridge #(.BAUD_DIV(BD), .TIMEOUT_BITS(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_pinRX(rx), .o_pinTX(tx),
      .o_memAddr(addr), .o_memDataOut(dout), .o_memWrEn(wr_en),
      .o_memRdEn(rd_en), .i_memDataIn(din), .o_busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // strobe monitor
   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt++;
         wr_addr = addr;
         wr_data = dout;
      end
      if (rd_en) begin
         rd_cnt++;
         rd_addr = addr;
         rd_cyc  = cyc;
      end
   end

   // TX line decoder: samples each bit at its middle
   initial begin : txmon
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev && !tx) begin
            tx_starts.push_back(cyc);
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = tx;
            end
            repeat (BD) @(negedge clk);
            if (!tx) tx_bad++;
            tx_q.push_back(b);
         end
         prev = tx;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BD) @(negedge clk);
      end
      rx = stop;
      repeat (BD) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tx(input int n, input string tag);
      int k;
      k = 0;
      while (tx_q.size() < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(tx_q.size()), 32'(n));
   endtask

   task automatic clear_tx();
      tx_q.delete();
      tx_starts.delete();
   endtask

   initial begin : main
      int wr0, rd0, ns, k, target;
      rst = 1'b1;
      rx  = 1'b1;
      din = 16'hBEEF;
      idle(3);
      // reset state
      chk("rst_tx",   32'(tx), 1);
      chk("rst_wr",   32'(wr_en), 0);
      chk("rst_rd",   32'(rd_en), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      idle(10);

      // ---- write 0x1234 <= 0xABCD
      clear_tx();
      send_byte(8'h57, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
      send_byte(8'hCD, 1); send_byte(8'hAB, 1);
      idle(4);
      chk("wr_count", 32'(wr_cnt), 1);
      chk("wr_addr",  32'(wr_addr), 32'h1234);
      chk("wr_data",  32'(wr_data), 32'hABCD);
      chk("wr_no_rd", 32'(rd_cnt), 0);
      chk("wr_busy",  32'(busy), 1);
      wait_tx(1, "wr_resp_len");
      chk("wr_ack", 32'(tx_q[0]), 32'h06);
      idle(6);
      chk("wr_busy_end", 32'(busy), 0);
      chk("wr_addr_hold", 32'(addr), 32'h1234);
      chk("wr_dout_hold", 32'(dout), 32'hABCD);

      // ---- read 0x0002 -> BEEF
      clear_tx();
      send_byte(8'h52, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
      idle(4);
      chk("rd_count", 32'(rd_cnt), 1);
      chk("rd_addr",  32'(rd_addr), 32'h0002);
      wait_tx(2, "rd_resp_len");
      chk("rd_lo", 32'(tx_q[0]), 32'hEF);
      chk("rd_hi", 32'(tx_q[1]), 32'hBE);
      chk("rd_start_lat", 32'(tx_starts[0] - rd_cyc), 1);
      chk("rd_b2b", 32'(tx_starts[1] - tx_starts[0]), 32'(10 * BD));
      idle(6);
      chk("rd_busy_end", 32'(busy), 0);

      // ---- noise: stray byte, short glitch, framing error
      clear_tx();
      wr0 = wr_cnt; rd0 = rd_cnt;
      send_byte(8'h41, 1);
      idle(16);
      rx = 1'b0; idle(2); rx = 1'b1;
      idle(16);
      send_byte(8'h52, 0);
      idle(24);
      chk("noise_wr", 32'(wr_cnt - wr0), 0);
      chk("noise_rd", 32'(rd_cnt - rd0), 0);
      chk("noise_tx", 32'(tx_starts.size()), 0);
      chk("noise_busy", 32'(busy), 0);
      send_byte(8'h52, 1); send_byte(8'h10, 1); send_byte(8'h00, 1);
      idle(4);
      chk("noise_rd_after", 32'(rd_cnt - rd0), 1);
      chk("noise_rd_addr", 32'(rd_addr), 32'h0010);
      wait_tx(2, "noise_resp_len");
      chk("noise_rd_lo", 32'(tx_q[0]), 32'hEF);
      idle(10);

      // ---- timeout after 'W' 0x34
      clear_tx();
      wr0 = wr_cnt; rd0 = rd_cnt;
      send_byte(8'h57, 1); send_byte(8'h34, 1);
      idle(33 * BD);
      chk("to_busy", 32'(busy), 0);
      send_byte(8'h52, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
      idle(4);
      chk("to_no_wr", 32'(wr_cnt - wr0), 0);
      chk("to_rd", 32'(rd_cnt - rd0), 1);
      chk("to_rd_addr", 32'(rd_addr), 32'h0000);
      wait_tx(2, "to_resp_len");
      idle(10);
      chk("to_resp_total", 32'(tx_q.size()), 2);

      // ---- bytes arriving during RESP are dropped
      clear_tx();
      wr0 = wr_cnt; rd0 = rd_cnt;
      send_byte(8'h52, 1); send_byte(8'h04, 1); send_byte(8'h00, 1);
      send_byte(8'h57, 1); send_byte(8'h06, 1); send_byte(8'h00, 1);
      send_byte(8'h11, 1); send_byte(8'h22, 1);
      idle(20);
      chk("ovl_rd", 32'(rd_cnt - rd0), 1);
      chk("ovl_no_wr", 32'(wr_cnt - wr0), 0);
      chk("ovl_resp_len", 32'(tx_q.size()), 2);
      chk("ovl_busy", 32'(busy), 0);
      clear_tx();
      send_byte(8'h57, 1); send_byte(8'h08, 1); send_byte(8'h00, 1);
      send_byte(8'h33, 1); send_byte(8'h44, 1);
      idle(4);
      chk("ovl_wr", 32'(wr_cnt - wr0), 1);
      chk("ovl_wr_addr", 32'(wr_addr), 32'h0008);
      chk("ovl_wr_data", 32'(wr_data), 32'h4433);
      wait_tx(1, "ovl_ack_len");
      chk("ovl_ack", 32'(tx_q[0]), 32'h06);
      idle(10);

      // ---- reset during third data bit of a read response (bit is 0)
      clear_tx();
      din = 16'h5A00;
      send_byte(8'h52, 1); send_byte(8'h0A, 1); send_byte(8'h00, 1);
      k = 0;
      while (tx_starts.size() == 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      ns = tx_starts.size();
      chk("rst_tx_started", 32'(ns), 1);
      if (ns > 0) begin
         target = tx_starts[0] + 3 * BD + 3;
         k = 0;
         while (cyc < target && k < 200) begin
            @(negedge clk);
            k++;
         end
      end
      chk("pre_rst_tx_low", 32'(tx), 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx",   32'(tx), 1);
      chk("mid_rst_addr", 32'(addr), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_wr",   32'(wr_en), 0);
      chk("mid_rst_rd",   32'(rd_en), 0);
      idle(3);
      rst = 1'b0;
      idle(120);
      chk("post_rst_tx", 32'(tx), 1);
      clear_tx();
      tx_bad = 0;
      wr0 = wr_cnt;
      send_byte(8'h57, 1); send_byte(8'h0C, 1); send_byte(8'h00, 1);
      send_byte(8'h78, 1); send_byte(8'h56, 1);
      idle(4);
      chk("post_wr", 32'(wr_cnt - wr0), 1);
      chk("post_wr_addr", 32'(wr_addr), 32'h000C);
      chk("post_wr_data", 32'(wr_data), 32'h5678);
      wait_tx(1, "post_ack_len");
      chk("post_ack", 32'(tx_q[0]), 32'h06);
      chk("tx_stop_bits", 32'(tx_bad), 0);
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
